// File: rtl/fp_mult_pipe_pkg.sv
// Shared constants and field helpers for the sign | biased exponent | fraction float format.
package fp_pkg;

    localparam int unsigned ROUND_RTZ = 0;
    localparam int unsigned ROUND_RNE = 1;

    // Helpers work on a zero-extended word so one definition serves every EXP_W/MAN_W.
    localparam int unsigned FP_MAX_W = 64;
    typedef logic [FP_MAX_W-1:0] fp_word_t;

    function automatic int unsigned bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    function automatic logic fp_sign(input fp_word_t x, input int unsigned exp_w,
                                     input int unsigned man_w);
        return ((x >> (exp_w + man_w)) & fp_word_t'(1)) != '0;
    endfunction

    function automatic fp_word_t fp_exp(input fp_word_t x, input int unsigned exp_w,
                                        input int unsigned man_w);
        return (x >> man_w) & ((fp_word_t'(1) << exp_w) - fp_word_t'(1));
    endfunction

    function automatic fp_word_t fp_frac(input fp_word_t x, input int unsigned man_w);
        return x & ((fp_word_t'(1) << man_w) - fp_word_t'(1));
    endfunction

endpackage

// File: rtl/fp_mult_pipe_norm_round.sv
// Combinational normalise + round of the raw mantissa product.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W      = 7,
    parameter int unsigned MAN_W      = 16,
    parameter int unsigned ROUND_MODE = ROUND_RNE
) (
    input  logic        [2*MAN_W+1:0] prod,
    input  logic signed [EXP_W+1:0]   exp_in,
    output logic        [MAN_W-1:0]   frac,
    output logic signed [EXP_W+1:0]   exp_out,
    output logic                      carry
);

    localparam int unsigned PW = 2*MAN_W + 2;
    localparam int unsigned EW = EXP_W + 2;

    logic [PW-1:0]    norm;
    logic [MAN_W-1:0] trunc;
    logic             guard;
    logic             sticky;
    logic             inc;

    always_comb begin
        // Align so the hidden bit always sits at PW-1; fraction, guard, sticky follow below it.
        norm   = prod[PW-1] ? prod : (prod << 1);
        trunc  = norm[PW-2 -: MAN_W];
        guard  = norm[MAN_W];
        sticky = |norm[MAN_W-1:0];
        inc    = (ROUND_MODE == ROUND_RNE) && guard && (sticky || trunc[0]);
        {carry, frac} = {1'b0, trunc} + (MAN_W+1)'(inc);
        exp_out = exp_in + EW'(prod[PW-1]);
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage floating-point multiplier with valid/ready handshakes, saturation and flush-to-zero.
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W      = 7,
    parameter int unsigned MAN_W      = 16,
    parameter int unsigned ROUND_MODE = ROUND_RNE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_data,
    output logic                     out_overflow,
    output logic                     out_underflow
);

    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned EW = EXP_W + 2;
    localparam int unsigned PW = 2*MAN_W + 2;

    localparam logic signed [EW-1:0] EXP_BIAS = EW'(bias(EXP_W));
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((32'd1 << EXP_W) - 32'd1);
    localparam logic signed [EW-1:0] EXP_MIN  = EW'(1);

    logic adv;

    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 sign_n, zero_n;
    logic signed [EW-1:0] exp_n;
    logic [PW-1:0]        prod_n;

    logic                 s1_valid, s1_sign, s1_zero;
    logic signed [EW-1:0] s1_exp;
    logic [PW-1:0]        s1_prod;

    logic [MAN_W-1:0]     nr_frac;
    logic signed [EW-1:0] nr_exp;
    logic                 nr_carry;

    logic                 s2_valid, s2_sign, s2_zero;
    logic signed [EW-1:0] s2_exp;
    logic [MAN_W-1:0]     s2_frac;

    logic [W-1:0]         pack_n;
    logic                 ovf_n, unf_n;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        ea     = EXP_W'(fp_exp(fp_word_t'(in_a), EXP_W, MAN_W));
        eb     = EXP_W'(fp_exp(fp_word_t'(in_b), EXP_W, MAN_W));
        fa     = MAN_W'(fp_frac(fp_word_t'(in_a), MAN_W));
        fb     = MAN_W'(fp_frac(fp_word_t'(in_b), MAN_W));
        sign_n = fp_sign(fp_word_t'(in_a), EXP_W, MAN_W) ^ fp_sign(fp_word_t'(in_b), EXP_W, MAN_W);
        zero_n = (ea == '0) || (eb == '0);
        exp_n  = {2'b00, ea} + {2'b00, eb} - EXP_BIAS;
        prod_n = PW'({1'b1, fa}) * PW'({1'b1, fb});
    end

    fp_norm_round #(
        .EXP_W      (EXP_W),
        .MAN_W      (MAN_W),
        .ROUND_MODE (ROUND_MODE)
    ) u_norm_round (
        .prod    (s1_prod),
        .exp_in  (s1_exp),
        .frac    (nr_frac),
        .exp_out (nr_exp),
        .carry   (nr_carry)
    );

    always_comb begin
        pack_n = '0;
        ovf_n  = 1'b0;
        unf_n  = 1'b0;
        if (s2_zero) begin
            pack_n[W-1] = s2_sign;
        end else if (s2_exp > EXP_MAX) begin
            pack_n = {s2_sign, {(W-1){1'b1}}};
            ovf_n  = 1'b1;
        end else if (s2_exp < EXP_MIN) begin
            pack_n[W-1] = s2_sign;
            unf_n       = 1'b1;
        end else begin
            pack_n = {s2_sign, s2_exp[EXP_W-1:0], s2_frac};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_sign       <= 1'b0;
            s1_zero       <= 1'b0;
            s1_exp        <= '0;
            s1_prod       <= '0;
            s2_valid      <= 1'b0;
            s2_sign       <= 1'b0;
            s2_zero       <= 1'b0;
            s2_exp        <= '0;
            s2_frac       <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else if (adv) begin
            s1_valid      <= in_valid;
            s1_sign       <= sign_n;
            s1_zero       <= zero_n;
            s1_exp        <= exp_n;
            s1_prod       <= prod_n;
            s2_valid      <= s1_valid;
            s2_sign       <= s1_sign;
            s2_zero       <= s1_zero;
            // Rounding carry folds into the exponent here; the fraction is already zero.
            s2_exp        <= nr_exp + EW'(nr_carry);
            s2_frac       <= nr_frac;
            out_valid     <= s2_valid;
            out_data      <= pack_n;
            out_overflow  <= ovf_n;
            out_underflow <= unf_n;
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Randomised bench for fp_mult_pipe: scoreboard against an arithmetic model, plus directed stall/reset cases.
module tb_fp_mult_pipe;

    localparam int unsigned EXP_W = 7;
    localparam int unsigned MAN_W = 16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready, rtz_in_ready;
    logic [23:0] in_a, in_b;
    logic        out_valid, rtz_out_valid;
    logic        out_ready;
    logic [23:0] out_data, rtz_out_data;
    logic        out_overflow, rtz_out_overflow;
    logic        out_underflow, rtz_out_underflow;

    logic        gold_en;
    logic [23:0] gold, gold_rtz;
    int          rdy_mode;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_out   = 0;

    typedef struct {
        logic [23:0] data;
        logic        ovf;
        logic        unf;
    } res_t;

    typedef struct {
        res_t        rne;
        res_t        rtz;
        logic        gold_en;
        logic [23:0] gold;
        logic [23:0] gold_rtz;
    } exp_t;

    exp_t sb[$];

    fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .ROUND_MODE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_overflow(out_overflow), .out_underflow(out_underflow)
    );

    fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .ROUND_MODE(0)) dut_rtz (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rtz_in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(rtz_out_valid), .out_ready(out_ready),
        .out_data(rtz_out_data), .out_overflow(rtz_out_overflow), .out_underflow(rtz_out_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Value-level model: exact integer product, rounded by comparing the remainder with half an ulp.
    function automatic res_t model(input logic [23:0] a, input logic [23:0] b, input bit rne);
        res_t            r;
        longint unsigned p, q, rem, half;
        int              e, sh;
        logic            s;
        s     = a[23] ^ b[23];
        r.ovf = 1'b0;
        r.unf = 1'b0;
        r.data = {s, 23'd0};
        if (a[22:16] == 7'd0 || b[22:16] == 7'd0) return r;
        p  = longint'({1'b1, a[15:0]}) * longint'({1'b1, b[15:0]});
        e  = int'(a[22:16]) + int'(b[22:16]) - 63;
        sh = 16;
        if (p >= (64'd1 << 33)) begin
            sh = 17;
            e++;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rne && (rem > half || (rem == half && q[0]))) q++;
        if (q == (64'd1 << 17)) begin
            q = q >> 1;
            e++;
        end
        if (e > 127) begin
            r.data = {s, 23'h7FFFFF};
            r.ovf  = 1'b1;
        end else if (e < 1) begin
            r.data = {s, 23'd0};
            r.unf  = 1'b1;
        end else begin
            r.data = {s, e[6:0], q[15:0]};
        end
        return r;
    endfunction

    function automatic logic [23:0] rand_op();
        logic [6:0] e;
        int         sel;
        sel = $urandom_range(0, 9);
        if (sel == 0)      e = 7'd0;
        else if (sel == 1) e = 7'($urandom_range(0, 127));
        else if (sel == 2) e = 7'($urandom_range(90, 127));
        else               e = 7'($urandom_range(40, 86));
        return {1'($urandom_range(0, 1)), e, 16'($urandom)};
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    always @(negedge clk) begin
        exp_t ex;
        if (!rst) begin
            if (in_valid && in_ready) begin
                ex.rne      = model(in_a, in_b, 1'b1);
                ex.rtz      = model(in_a, in_b, 1'b0);
                ex.gold_en  = gold_en;
                ex.gold     = gold;
                ex.gold_rtz = gold_rtz;
                sb.push_back(ex);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    ex = sb.pop_front();
                    n_out++;
                    check("rne_data", 64'(out_data), 64'(ex.rne.data));
                    check("rne_ovf", 64'(out_overflow), 64'(ex.rne.ovf));
                    check("rne_unf", 64'(out_underflow), 64'(ex.rne.unf));
                    check("rtz_valid", 64'(rtz_out_valid), 64'd1);
                    check("rtz_data", 64'(rtz_out_data), 64'(ex.rtz.data));
                    check("rtz_ovf", 64'(rtz_out_overflow), 64'(ex.rtz.ovf));
                    check("rtz_unf", 64'(rtz_out_underflow), 64'(ex.rtz.unf));
                    if (ex.gold_en) begin
                        check("gold_rne", 64'(out_data), 64'(ex.gold));
                        check("gold_rtz", 64'(rtz_out_data), 64'(ex.gold_rtz));
                    end
                end
            end
        end
    end

    task automatic send(input logic [23:0] a, input logic [23:0] b, input bit g_en,
                        input logic [23:0] g, input logic [23:0] g_rtz);
        int unsigned waited;
        waited   = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        gold_en  = g_en;
        gold     = g;
        gold_rtz = g_rtz;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                check("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        gold_en  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [23:0] sa[5];
        logic [23:0] sbv[5];
        res_t        first;
        int          lat;
        int          base;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        gold_en  = 1'b0;
        gold     = '0;
        gold_rtz = '0;
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_ovf", 64'(out_overflow), 64'd0);
        check("rst_unf", 64'(out_underflow), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        idle(1);

        // Latency: accepting edge counts as 1, result must be visible after the third edge.
        in_valid = 1'b1;
        in_a     = 24'h3F8000;
        in_b     = 24'h3F8000;
        gold_en  = 1'b1;
        gold     = 24'h402000;
        gold_rtz = 24'h402000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        gold_en  = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'd3);
        check("lat_data", 64'(out_data), 64'h402000);
        idle(3);

        send(24'h3F8000, 24'h3F8000, 1'b1, 24'h402000, 24'h402000);
        send(24'hC00000, 24'h408000, 1'b1, 24'hC18000, 24'hC18000);
        send(24'h3F0001, 24'h3F8000, 1'b1, 24'h3F8002, 24'h3F8001);
        send(24'h7F0000, 24'h7F0000, 1'b1, 24'h7FFFFF, 24'h7FFFFF);
        send(24'h810000, 24'h010000, 1'b1, 24'h800000, 24'h800000);
        send(24'h000123, 24'h3F8000, 1'b1, 24'h000000, 24'h000000);
        idle(6);

        // Back-pressure: five operands streamed while the consumer stops accepting.
        for (int i = 0; i < 5; i++) begin
            sa[i]  = rand_op();
            sbv[i] = rand_op();
        end
        first = model(sa[0], sbv[0], 1'b1);
        base  = n_out;
        fork
            begin
                for (int i = 0; i < 5; i++) send(sa[i], sbv[i], 1'b0, '0, '0);
            end
            begin
                int w;
                @(posedge clk);
                @(posedge clk);
                rdy_mode = 1;
                w = 0;
                while (!out_valid && w < 20) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                check("stall_fill", 64'(out_valid), 64'd1);
                repeat (4) begin
                    @(posedge clk);
                    #1;
                    check("stall_hold", 64'(out_data), 64'(first.data));
                    check("stall_valid", 64'(out_valid), 64'd1);
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                end
                rdy_mode = 0;
            end
        join
        idle(8);
        check("stream_count", 64'(n_out - base), 64'd5);
        check("stream_sb_empty", 64'(sb.size()), 64'd0);

        // Reset with two results in flight: nothing may surface afterwards.
        send(rand_op(), rand_op(), 1'b0, '0, '0);
        send(rand_op(), rand_op(), 1'b0, '0, '0);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_data", 64'(out_data), 64'd0);
        check("midrst_flags", 64'({out_overflow, out_underflow}), 64'd0);
        check("midrst_rtz_valid", 64'(rtz_out_valid), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            check("post_rst_valid", 64'(out_valid), 64'd0);
        end

        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            send(rand_op(), rand_op(), 1'b0, '0, '0);
        end
        rdy_mode = 0;
        idle(12);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
